// File: rtl/phv_queue_arbiter.sv
// Round-robin reader for four first-word-fall-through PHV FIFOs.
// Emits one PHV per cycle over valid/ready and keeps per-queue dequeue counters.
module phv_queue_arbiter #(
  parameter int PHV_LEN      = 32*64+256,
  parameter int C_NUM_QUEUES = 4,
  parameter int QMAP_OFF     = 141,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                        axis_clk,
  input  logic                        aresetn,
  input  logic [PHV_LEN-1:0]          phv_in_0,
  input  logic [PHV_LEN-1:0]          phv_in_1,
  input  logic [PHV_LEN-1:0]          phv_in_2,
  input  logic [PHV_LEN-1:0]          phv_in_3,
  input  logic                        phv_in_valid_0,
  input  logic                        phv_in_valid_1,
  input  logic                        phv_in_valid_2,
  input  logic                        phv_in_valid_3,
  output logic                        phv_rd_en_0,
  output logic                        phv_rd_en_1,
  output logic                        phv_rd_en_2,
  output logic                        phv_rd_en_3,
  output logic [PHV_LEN-1:0]          phv_out,
  output logic [1:0]                  phv_out_qid,
  output logic                        phv_out_valid,
  input  logic                        phv_out_ready,
  input  logic                        cnt_clr,
  output logic [4*CNT_WIDTH-1:0]      q_pkt_cnt
);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_t;

  state_t                  state_q, state_d;
  logic [PHV_LEN-1:0]      phv_q, phv_d;
  logic [1:0]              qid_q, qid_d;
  logic [1:0]              last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]    cnt_q [C_NUM_QUEUES];
  logic [CNT_WIDTH-1:0]    cnt_d [C_NUM_QUEUES];

  logic [PHV_LEN-1:0]      phv_in [C_NUM_QUEUES];
  logic [C_NUM_QUEUES-1:0] in_valid;
  logic [C_NUM_QUEUES-1:0] rd_en;
  logic [1:0]              grant;
  logic [1:0]              idx;
  logic                    grant_vld;
  logic                    load;
  logic                    do_grant;

  assign phv_in[0] = phv_in_0;
  assign phv_in[1] = phv_in_1;
  assign phv_in[2] = phv_in_2;
  assign phv_in[3] = phv_in_3;
  assign in_valid  = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

  // First valid queue after the last grant; 2-bit index wraps naturally.
  always_comb begin
    grant_vld = 1'b0;
    grant     = last_grant_q;
    idx       = '0;
    for (int i = 1; i <= C_NUM_QUEUES; i++) begin
      idx = last_grant_q + 2'(i);
      if (!grant_vld && in_valid[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  assign load     = (state_q == ST_EMPTY) || phv_out_ready;
  assign do_grant = load && grant_vld;

  always_comb begin
    rd_en = '0;
    if (do_grant && aresetn) begin
      rd_en[grant] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    phv_d        = phv_q;
    qid_d        = qid_q;
    last_grant_d = last_grant_q;
    if (do_grant) begin
      phv_d                  = phv_in[grant];
      phv_d[QMAP_OFF +: 4]   = 4'b0001 << grant;
      qid_d                  = grant;
      last_grant_d           = grant;
      state_d                = ST_FULL;
    end else if (phv_out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Clear takes priority over a coincident grant.
  always_comb begin
    for (int q = 0; q < C_NUM_QUEUES; q++) begin
      cnt_d[q] = cnt_q[q];
      if (cnt_clr) begin
        cnt_d[q] = '0;
      end else if (do_grant && (grant == 2'(q))) begin
        cnt_d[q] = cnt_q[q] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_EMPTY;
      phv_q        <= '0;
      qid_q        <= '0;
      last_grant_q <= 2'd3;
      for (int q = 0; q < C_NUM_QUEUES; q++) begin
        cnt_q[q] <= '0;
      end
    end else begin
      state_q      <= state_d;
      phv_q        <= phv_d;
      qid_q        <= qid_d;
      last_grant_q <= last_grant_d;
      for (int q = 0; q < C_NUM_QUEUES; q++) begin
        cnt_q[q] <= cnt_d[q];
      end
    end
  end

  assign phv_out       = phv_q;
  assign phv_out_qid   = qid_q;
  assign phv_out_valid = (state_q == ST_FULL);
  assign phv_rd_en_0   = rd_en[0];
  assign phv_rd_en_1   = rd_en[1];
  assign phv_rd_en_2   = rd_en[2];
  assign phv_rd_en_3   = rd_en[3];

  for (genvar q = 0; q < C_NUM_QUEUES; q++) begin : g_cnt
    assign q_pkt_cnt[q*CNT_WIDTH +: CNT_WIDTH] = cnt_q[q];
  end

endmodule

// File: tb/tb_phv_queue_arbiter.sv
// Scoreboard bench for phv_queue_arbiter: modelled FWFT FIFOs feed the DUT,
// a negedge monitor checks every accepted PHV against the expected queue.
module tb_phv_queue_arbiter;

  localparam int PHV_LEN   = 32*64+256;
  localparam int QMAP_OFF  = 141;
  localparam int CNT_WIDTH = 4;

  typedef logic [PHV_LEN-1:0] phv_t;
  typedef struct packed {
    phv_t       data;
    logic [1:0] qid;
  } exp_t;

  logic                   axis_clk = 1'b0;
  logic                   aresetn;
  phv_t                   phv_in_0, phv_in_1, phv_in_2, phv_in_3;
  logic                   phv_in_valid_0, phv_in_valid_1, phv_in_valid_2, phv_in_valid_3;
  logic                   phv_rd_en_0, phv_rd_en_1, phv_rd_en_2, phv_rd_en_3;
  phv_t                   phv_out;
  logic [1:0]             phv_out_qid;
  logic                   phv_out_valid;
  logic                   phv_out_ready;
  logic                   cnt_clr;
  logic [4*CNT_WIDTH-1:0] q_pkt_cnt;

  phv_t fifo0[$], fifo1[$], fifo2[$], fifo3[$];
  exp_t exp_q[$];
  logic [3:0] rd_neg;
  int n_checks = 0;
  int n_pass   = 0;

  wire [3:0] rd_en = {phv_rd_en_3, phv_rd_en_2, phv_rd_en_1, phv_rd_en_0};

  phv_queue_arbiter #(
    .PHV_LEN(PHV_LEN),
    .C_NUM_QUEUES(4),
    .QMAP_OFF(QMAP_OFF),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .axis_clk(axis_clk),
    .aresetn(aresetn),
    .phv_in_0(phv_in_0),
    .phv_in_1(phv_in_1),
    .phv_in_2(phv_in_2),
    .phv_in_3(phv_in_3),
    .phv_in_valid_0(phv_in_valid_0),
    .phv_in_valid_1(phv_in_valid_1),
    .phv_in_valid_2(phv_in_valid_2),
    .phv_in_valid_3(phv_in_valid_3),
    .phv_rd_en_0(phv_rd_en_0),
    .phv_rd_en_1(phv_rd_en_1),
    .phv_rd_en_2(phv_rd_en_2),
    .phv_rd_en_3(phv_rd_en_3),
    .phv_out(phv_out),
    .phv_out_qid(phv_out_qid),
    .phv_out_valid(phv_out_valid),
    .phv_out_ready(phv_out_ready),
    .cnt_clr(cnt_clr),
    .q_pkt_cnt(q_pkt_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  function automatic phv_t make_phv(input int tag, input logic [3:0] bmap);
    phv_t p;
    p = '0;
    for (int w = 0; w < PHV_LEN/32; w++) begin
      p[w*32 +: 32] = 32'(tag * 32'h9E3779B1) ^ 32'(w << 8) ^ 32'h5A000000;
    end
    p[QMAP_OFF +: 4] = bmap;
    return p;
  endfunction

  function automatic phv_t exp_phv(input phv_t p, input int q);
    phv_t r;
    r = p;
    r[QMAP_OFF +: 4] = 4'b0001 << q;
    return r;
  endfunction

  function automatic logic [3:0] cnt_of(input int q);
    return q_pkt_cnt[q*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  task automatic update_heads();
    phv_in_0 = (fifo0.size() != 0) ? fifo0[0] : '0;
    phv_in_1 = (fifo1.size() != 0) ? fifo1[0] : '0;
    phv_in_2 = (fifo2.size() != 0) ? fifo2[0] : '0;
    phv_in_3 = (fifo3.size() != 0) ? fifo3[0] : '0;
    phv_in_valid_0 = (fifo0.size() != 0);
    phv_in_valid_1 = (fifo1.size() != 0);
    phv_in_valid_2 = (fifo2.size() != 0);
    phv_in_valid_3 = (fifo3.size() != 0);
  endtask

  task automatic push_fifo(input int q, input phv_t p);
    case (q)
      0: fifo0.push_back(p);
      1: fifo1.push_back(p);
      2: fifo2.push_back(p);
      default: fifo3.push_back(p);
    endcase
    update_heads();
  endtask

  task automatic expect_out(input phv_t p, input int q);
    exp_t e;
    e.data = exp_phv(p, q);
    e.qid  = 2'(q);
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input int q, input int tag, input logic [3:0] bmap);
    phv_t p;
    p = make_phv(tag, bmap);
    push_fifo(q, p);
    expect_out(p, q);
  endtask

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge axis_clk);
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      sample();
      if (fifo0.size() == 0 && fifo1.size() == 0 && fifo2.size() == 0 &&
          fifo3.size() == 0 && !phv_out_valid) begin
        done = 1'b1;
      end
    end
    if (!done) begin
      n_checks++;
      $display("[TB] FAIL %s: timeout, DUT still busy after 200 cycles", name);
    end
  endtask

  // Pop the modelled FIFOs with the strobe seen before the edge.
  always @(negedge axis_clk) rd_neg = rd_en;

  always @(posedge axis_clk) begin
    logic [3:0] fire;
    fire = rd_neg & {4{aresetn}};
    #1;
    if (fire[0] && fifo0.size() != 0) void'(fifo0.pop_front());
    if (fire[1] && fifo1.size() != 0) void'(fifo1.pop_front());
    if (fire[2] && fifo2.size() != 0) void'(fifo2.pop_front());
    if (fire[3] && fifo3.size() != 0) void'(fifo3.pop_front());
    update_heads();
  end

  always @(negedge axis_clk) begin
    exp_t e;
    if (aresetn && phv_out_valid && phv_out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL sb_unexpected: got qid %0d with nothing expected", phv_out_qid);
      end else begin
        e = exp_q.pop_front();
        if (phv_out !== e.data || phv_out_qid !== e.qid) begin
          $display("[TB] FAIL sb_phv: got qid %0d bmap %b lo 0x%h, expected qid %0d bmap %b lo 0x%h",
                   phv_out_qid, phv_out[QMAP_OFF +: 4], phv_out[63:0],
                   e.qid, e.data[QMAP_OFF +: 4], e.data[63:0]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    phv_t p_hold;
    int   vcount;

    aresetn       = 1'b0;
    phv_out_ready = 1'b0;
    cnt_clr       = 1'b0;
    rd_neg        = '0;
    update_heads();
    repeat (3) tick();
    sample();
    check_output("rst_valid", 64'(phv_out_valid), 64'd0);
    check_output("rst_qid", 64'(phv_out_qid), 64'd0);
    check_output("rst_phv_zero", 64'(phv_out == '0), 64'd1);
    check_output("rst_cnt", 64'(q_pkt_cnt), 64'd0);
    check_output("rst_rd_en", 64'(rd_en), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // Single PHV on queue 2.
    $display("[TB] single queue 2");
    phv_out_ready = 1'b1;
    apply_stimulus(2, 1, 4'b0100);
    sample();
    check_output("t1_rd_en_pulse", 64'(rd_en), 64'b0100);
    tick();
    sample();
    check_output("t1_rd_en_drop", 64'(rd_en), 64'd0);
    check_output("t1_valid", 64'(phv_out_valid), 64'd1);
    check_output("t1_qid", 64'(phv_out_qid), 64'd2);
    check_output("t1_bitmap", 64'(phv_out[QMAP_OFF +: 4]), 64'b0100);
    check_output("t1_cnt2", 64'(cnt_of(2)), 64'd1);
    wait_idle("t1_idle");

    // Fresh reset, then three PHVs per queue, round-robin from queue 0.
    $display("[TB] round robin 4x3");
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      for (int q = 0; q < 4; q++) begin
        apply_stimulus(q, 100 + k*4 + q, 4'(1 << q));
      end
    end
    sample();
    tick();
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      sample();
      if (phv_out_valid) vcount++;
      tick();
    end
    check_output("t2_back_to_back", 64'(vcount), 64'd12);
    sample();
    check_output("t2_valid_drop", 64'(phv_out_valid), 64'd0);
    for (int q = 0; q < 4; q++) begin
      check_output($sformatf("t2_cnt%0d", q), 64'(cnt_of(q)), 64'd3);
    end

    // Backpressure: hold a queue-0 PHV while queues 1 and 3 wait.
    $display("[TB] backpressure hold");
    tick();
    phv_out_ready = 1'b0;
    p_hold = make_phv(200, 4'b0001);
    push_fifo(0, p_hold);
    expect_out(p_hold, 0);
    tick();
    tick();
    apply_stimulus(1, 201, 4'b0010);
    apply_stimulus(3, 203, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      sample();
      check_output($sformatf("t3_rd_en_hold%0d", i), 64'(rd_en), 64'd0);
      check_output($sformatf("t3_phv_stable%0d", i), 64'(phv_out == exp_phv(p_hold, 0)), 64'd1);
      check_output($sformatf("t3_qid_stable%0d", i), 64'(phv_out_qid), 64'd0);
      tick();
    end
    phv_out_ready = 1'b1;
    sample();
    check_output("t3_release_grant", 64'(rd_en), 64'b0010);
    wait_idle("t3_idle");

    // Multicast copies in FIFOs 0, 1 and 3.
    $display("[TB] multicast split");
    tick();
    apply_stimulus(0, 300, 4'b1011);
    apply_stimulus(1, 300, 4'b1011);
    apply_stimulus(3, 300, 4'b1011);
    wait_idle("t4_idle");

    // Counter wrap and clear-over-grant priority.
    $display("[TB] counters");
    tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    sample();
    check_output("t5_clr_all", 64'(q_pkt_cnt), 64'd0);
    tick();
    for (int i = 0; i < 15; i++) apply_stimulus(0, 400 + i, 4'b0001);
    wait_idle("t5_idle15");
    check_output("t5_cnt0_max", 64'(cnt_of(0)), 64'd15);
    tick();
    apply_stimulus(0, 415, 4'b0001);
    wait_idle("t5_idle16");
    check_output("t5_cnt0_wrap", 64'(cnt_of(0)), 64'd0);
    tick();
    apply_stimulus(1, 500, 4'b0010);
    wait_idle("t5_idle_q1");
    check_output("t5_cnt1_one", 64'(cnt_of(1)), 64'd1);
    tick();
    apply_stimulus(1, 501, 4'b0010);
    cnt_clr = 1'b1;
    sample();
    check_output("t5_clr_grant_rd_en", 64'(rd_en), 64'b0010);
    tick();
    cnt_clr = 1'b0;
    sample();
    check_output("t5_clr_wins", 64'(cnt_of(1)), 64'd0);
    wait_idle("t5_idle_clr");

    // Asynchronous reset while holding a PHV with queues pending.
    $display("[TB] reset mid-operation");
    tick();
    phv_out_ready = 1'b0;
    push_fifo(2, make_phv(600, 4'b0100));
    tick();
    tick();
    apply_stimulus(0, 601, 4'b0001);
    apply_stimulus(1, 602, 4'b0010);
    tick();
    sample();
    check_output("t6_full_before", 64'(phv_out_valid), 64'd1);
    check_output("t6_hold_rd_en", 64'(rd_en), 64'd0);
    #2;
    aresetn = 1'b0;
    #1;
    check_output("t6_async_valid", 64'(phv_out_valid), 64'd0);
    phv_out_ready = 1'b1;
    #1;
    check_output("t6_rst_rd_en", 64'(rd_en), 64'd0);
    tick();
    tick();
    check_output("t6_fifo0_kept", 64'(fifo0.size()), 64'd1);
    check_output("t6_fifo1_kept", 64'(fifo1.size()), 64'd1);
    aresetn = 1'b1;
    sample();
    check_output("t6_first_grant_q0", 64'(rd_en), 64'b0001);
    wait_idle("t6_idle");
    check_output("t6_cnt0", 64'(cnt_of(0)), 64'd1);
    check_output("t6_cnt1", 64'(cnt_of(1)), 64'd1);
    check_output("t6_cnt2", 64'(cnt_of(2)), 64'd0);

    check_output("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/phv_queue_arbiter.md
# phv_queue_arbiter

Egress-side reader for the four per-queue PHV FIFOs filled by the final match-action stage. It pops completed PHVs from the FIFO outputs in round-robin order and presents one PHV per cycle to the deparser over a valid/ready handshake. It rewrites the queue bitmap so that each output PHV names exactly one queue, and it keeps per-queue dequeue counters.

## Interface
Parameters:
- PHV_LEN, 32*64+256: PHV width in bits.
- C_NUM_QUEUES, 4: number of queues. Fixed at 4; other values are unsupported.
- QMAP_OFF, 141: LSB of the 4-bit queue bitmap inside the PHV. Bit QMAP_OFF+q selects queue q.
- CNT_WIDTH, 32: width of each dequeue counter.

Ports:
- axis_clk  in  1  clock.
- aresetn  in  1  asynchronous, active-low reset.
- phv_in_0..phv_in_3  in  PHV_LEN each  head-of-FIFO data. FIFOs are first-word-fall-through.
- phv_in_valid_0..phv_in_valid_3  in  1 each  FIFO q is non-empty.
- phv_rd_en_0..phv_rd_en_3  out  1 each  pop strobe for FIFO q. One cycle per PHV.
- phv_out  out  PHV_LEN  PHV to the deparser, with the bitmap rewritten.
- phv_out_qid  out  2  queue that sourced phv_out.
- phv_out_valid  out  1  phv_out is valid.
- phv_out_ready  in  1  deparser accepts.
- cnt_clr  in  1  synchronous clear of all counters.
- q_pkt_cnt  out  4*CNT_WIDTH  dequeue counters. Queue q occupies bits [q*CNT_WIDTH +: CNT_WIDTH].

## Operation
- The output register holds at most one PHV. FSM states:
  - EMPTY: phv_out_valid=0.
  - FULL: phv_out_valid=1.
- load = (state==EMPTY) || phv_out_ready.
- Arbitration, only when load=1 and any phv_in_valid_q=1:
  - Search order is last_grant+1, +2, +3, +4, all mod 4.
  - The first valid queue in that order is the grant g.
  - phv_rd_en_g=1 in that cycle, combinationally. All other rd_en are 0.
- Capture, on the same clock edge as the pop:
  - phv_out ← phv_in_g, except phv_out[QMAP_OFF+:4] ← 4'b0001<<g.
  - phv_out_qid ← g, last_grant ← g, state ← FULL.
  - q_pkt_cnt[g] increments by 1 and wraps from 2^CNT_WIDTH−1 to 0.
- Transitions:
  - EMPTY→FULL on a grant.
  - FULL→FULL on ready with a grant. This is back-to-back; the new PHV replaces the old one.
  - FULL→EMPTY on ready with no valid input.
  - FULL→FULL holding on no ready. phv_out and phv_out_qid stay stable and all rd_en are 0.
- The bitmap bit of the input PHV is not checked. The FIFO index alone decides g. A multicast PHV arrives as separate copies in several FIFOs, and each copy is emitted separately.
- Counters:
  - cnt_clr=1 zeroes all counters.
  - If a grant occurs in the same cycle, the granted counter ends at 0. Clear wins; that PHV is not counted.
- rd_en never asserts while aresetn=0.

## Timing
- Reset values:
  - phv_out=0, phv_out_qid=0, phv_out_valid=0, state=EMPTY.
  - last_grant=3, so queue 0 has first priority.
  - All q_pkt_cnt=0, all phv_rd_en=0.
- Latency: 1 cycle from pop (rd_en high) to phv_out_valid.
- Throughput: 1 PHV per cycle while phv_out_ready=1 and any input is valid.
- rd_en is a combinational function of registered state, the valids and phv_out_ready. There is no combinational path from phv_in data to any output.
- Reset asserted mid-operation:
  - The held PHV is discarded.
  - phv_out_valid drops immediately, asynchronously.
  - No FIFO is popped. The pop is lost only if the edge coincided with a rd_en cycle.
- Fairness: with all four queues continuously valid and ready=1, the grant sequence is 0,1,2,3,0,…

## Test plan
- Reset, then queue 2 alone valid with a PHV whose bitmap is 4'b0100, ready=1 → rd_en_2 pulses 1 cycle; next cycle phv_out_valid=1, qid=2, bitmap 4'b0100; q_pkt_cnt[2]=1.
- All four queues hold 3 PHVs each, ready=1 → 12 consecutive outputs with qid 0,1,2,3 repeating; all counters=3; valid drops after the 12th.
- Output FULL, ready=0 for 5 cycles with queues 1 and 3 valid → no rd_en; phv_out stable. On release, the next grant follows last_grant.
- Same multicast PHV (bitmap 4'b1011) pushed into FIFOs 0, 1 and 3 → three outputs with bitmaps 4'b0001, 4'b0010, 4'b1000.
- Preload q_pkt_cnt[0]=2^32−1 via traffic (or reduce CNT_WIDTH to 4 and send 16 PHVs) → counter wraps to 0. Assert cnt_clr on the same cycle as a grant → that counter reads 0.
- Assert aresetn low while FULL and queues valid → phv_out_valid=0 at once, no rd_en. After release, the first grant is queue 0.
